// File: rtl/upsample_seq_ctrl.sv
// upsample_seq_ctrl
// Sequencer for the 18-bit transmit up-sampling chain. A cascade of three
// counters divides the system clock into one-cycle sample, interpolation and
// symbol strobes. One symbol is fetched per symbol period over a valid/ready
// handshake and presented zero-stuffed on x_out (non-zero only at phase 0).
// A small FSM handles start-up (PRIME), steady streaming (RUN), the zero-symbol
// tail after enable drops (FLUSH), and a sticky underflow flag.

module upsample_seq_ctrl #(
    parameter int SAM_DIV    = 4,
    parameter int INT_RATIO  = 2,
    parameter int SYM_RATIO  = 2,
    parameter int FLUSH_SYMS = 8,
    localparam int PH_N = INT_RATIO * SYM_RATIO,
    localparam int PW   = (PH_N > 1) ? $clog2(PH_N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sym_valid,
    input  logic [17:0]   sym_data,
    output logic          sym_ready,
    input  logic          clr_underflow,
    output logic          sam_en,
    output logic          int_en,
    output logic          sym_en,
    output logic [PW-1:0] phase,
    output logic [17:0]   x_out,
    output logic          running,
    output logic          underflow
);

    // Counter widths; a divide-by-one stage still gets a one-bit counter that
    // simply stays at zero.
    localparam int SW = (SAM_DIV   > 1) ? $clog2(SAM_DIV)   : 1;
    localparam int IW = (INT_RATIO > 1) ? $clog2(INT_RATIO) : 1;
    localparam int YW = (SYM_RATIO > 1) ? $clog2(SYM_RATIO) : 1;
    localparam int FW = $clog2(FLUSH_SYMS + 1);

    localparam logic [SW-1:0] SAM_LAST   = SW'(SAM_DIV - 1);
    localparam logic [IW-1:0] INT_LAST   = IW'(INT_RATIO - 1);
    localparam logic [YW-1:0] SYM_LAST   = YW'(SYM_RATIO - 1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_SYMS);
    localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [SW-1:0] sam_cnt;
    logic [IW-1:0] int_cnt;
    logic [YW-1:0] sym_cnt;
    logic [FW-1:0] flush_cnt;
    logic [17:0]   sym_reg;

    logic [17:0]   sym_next;
    logic          flush_load;
    logic          flush_dec;
    logic          uf_set;

    // Strobes are pure decodes of the counter cascade, so each one lands in
    // the same cycle the counters below it wrap.
    assign running = (state == RUN) || (state == FLUSH);
    assign sam_en  = running && (sam_cnt == SAM_LAST);
    assign int_en  = sam_en  && (int_cnt == INT_LAST);
    assign sym_en  = int_en  && (sym_cnt == SYM_LAST);

    // Sample index within the symbol; truncation to PW bits is exact because
    // the largest value is PH_N-1.
    assign phase = PW'(int_cnt) + PW'(INT_RATIO) * PW'(sym_cnt);

    // Zero-stuffing: the held symbol only appears at the first sample slot.
    assign x_out = (running && (phase == '0)) ? sym_reg : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and symbol-load decisions.
    always_comb begin
        state_next = state;
        sym_ready  = 1'b0;
        sym_next   = sym_reg;
        flush_load = 1'b0;
        flush_dec  = 1'b0;
        uf_set     = 1'b0;
        case (state)
            IDLE: begin
                sym_next = '0;
                if (enable) begin
                    state_next = PRIME;
                end
            end
            PRIME: begin
                sym_ready = 1'b1;
                if (!enable) begin
                    state_next = IDLE;
                end else if (sym_valid) begin
                    sym_next   = sym_data;
                    state_next = RUN;
                end
            end
            RUN: begin
                sym_ready = sym_en && enable;
                if (sym_en) begin
                    if (enable) begin
                        if (sym_valid) begin
                            sym_next = sym_data;
                        end else begin
                            sym_next = '0;
                            uf_set   = 1'b1;
                        end
                    end else begin
                        sym_next   = '0;
                        flush_load = 1'b1;
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                sym_next = '0;
                if (sym_en) begin
                    flush_dec = 1'b1;
                    if (flush_cnt == FLUSH_ONE) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Held symbol and remaining flush-period count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sym_reg   <= '0;
            flush_cnt <= '0;
        end else begin
            sym_reg <= sym_next;
            if (flush_load) begin
                flush_cnt <= FLUSH_INIT;
            end else if (flush_dec) begin
                flush_cnt <= flush_cnt - FW'(1);
            end
        end
    end

    // Counter cascade: held at zero unless running, each stage steps on the
    // strobe of the stage below and wraps when its own strobe fires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sam_cnt <= '0;
            int_cnt <= '0;
            sym_cnt <= '0;
        end else if (!running) begin
            sam_cnt <= '0;
            int_cnt <= '0;
            sym_cnt <= '0;
        end else begin
            sam_cnt <= sam_en ? '0 : sam_cnt + SW'(1);
            if (sam_en) begin
                int_cnt <= int_en ? '0 : int_cnt + IW'(1);
            end
            if (int_en) begin
                sym_cnt <= sym_en ? '0 : sym_cnt + YW'(1);
            end
        end
    end

    // Sticky underflow; a new underflow in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            underflow <= 1'b0;
        end else if (uf_set) begin
            underflow <= 1'b1;
        end else if (clr_underflow) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_upsample_seq_ctrl.sv
// tb_upsample_seq_ctrl
// Drives two sequencers from the same inputs: the default configuration and a
// fully undivided one (all ratios 1). A behavioural model based on a single
// position-in-symbol counter predicts every output in every cycle.

module tb_upsample_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sym_valid;
    logic        clr_underflow;
    logic [17:0] sym_data;

    logic        sym_ready0, sam_en0, int_en0, sym_en0, running0, underflow0;
    logic [1:0]  phase0;
    logic [17:0] x_out0;

    logic        sym_ready1, sam_en1, int_en1, sym_en1, running1, underflow1;
    logic [0:0]  phase1;
    logic [17:0] x_out1;

    upsample_seq_ctrl dut0 (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sym_valid     (sym_valid),
        .sym_data      (sym_data),
        .sym_ready     (sym_ready0),
        .clr_underflow (clr_underflow),
        .sam_en        (sam_en0),
        .int_en        (int_en0),
        .sym_en        (sym_en0),
        .phase         (phase0),
        .x_out         (x_out0),
        .running       (running0),
        .underflow     (underflow0)
    );

    upsample_seq_ctrl #(
        .SAM_DIV    (1),
        .INT_RATIO  (1),
        .SYM_RATIO  (1),
        .FLUSH_SYMS (2)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sym_valid     (sym_valid),
        .sym_data      (sym_data),
        .sym_ready     (sym_ready1),
        .clr_underflow (clr_underflow),
        .sam_en        (sam_en1),
        .int_en        (int_en1),
        .sym_en        (sym_en1),
        .phase         (phase1),
        .x_out         (x_out1),
        .running       (running1),
        .underflow     (underflow1)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Per-instance configuration.
    int p_sd[2] = '{4, 1};
    int p_ir[2] = '{2, 1};
    int p_sr[2] = '{2, 1};
    int p_fs[2] = '{8, 2};

    // Model state: mode 0 idle, 1 priming, 2 streaming, 3 flushing; t is the
    // clock position inside the current symbol period.
    int          m_mode[2];
    int          m_t[2];
    int          m_flush[2];
    logic        m_uf[2];
    logic [17:0] m_cur[2];
    bit          m_known = 1'b0;

    logic [17:0] src[$];
    logic [31:0] exp_v[8];
    logic [31:0] obs_v[8];
    string       names[8] = '{"sam_en", "int_en", "sym_en", "phase",
                              "x_out", "sym_ready", "running", "underflow"};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_expect(input int k, input logic en);
        int per;
        bit run;
        per = p_sd[k] * p_ir[k] * p_sr[k];
        run = (m_mode[k] == 2) || (m_mode[k] == 3);
        exp_v[0] = 32'(run && ((m_t[k] % p_sd[k]) == p_sd[k] - 1));
        exp_v[1] = 32'(run && ((m_t[k] % (p_sd[k] * p_ir[k])) == p_sd[k] * p_ir[k] - 1));
        exp_v[2] = 32'(run && (m_t[k] == per - 1));
        exp_v[3] = run ? 32'(m_t[k] / p_sd[k]) : 32'd0;
        exp_v[4] = (run && (m_t[k] < p_sd[k])) ? {14'd0, m_cur[k]} : 32'd0;
        exp_v[5] = 32'((m_mode[k] == 1) || ((m_mode[k] == 2) && (m_t[k] == per - 1) && en));
        exp_v[6] = 32'(run);
        exp_v[7] = 32'(m_uf[k]);
    endtask

    task automatic observe(input int k);
        if (k == 0) begin
            obs_v[0] = 32'(sam_en0);
            obs_v[1] = 32'(int_en0);
            obs_v[2] = 32'(sym_en0);
            obs_v[3] = 32'(phase0);
            obs_v[4] = 32'(x_out0);
            obs_v[5] = 32'(sym_ready0);
            obs_v[6] = 32'(running0);
            obs_v[7] = 32'(underflow0);
        end else begin
            obs_v[0] = 32'(sam_en1);
            obs_v[1] = 32'(int_en1);
            obs_v[2] = 32'(sym_en1);
            obs_v[3] = 32'(phase1);
            obs_v[4] = 32'(x_out1);
            obs_v[5] = 32'(sym_ready1);
            obs_v[6] = 32'(running1);
            obs_v[7] = 32'(underflow1);
        end
    endtask

    task automatic model_update(input int k, input logic rst, input logic en,
                                input logic vld, input logic clr, input logic [17:0] dat);
        int per;
        bit set;
        per = p_sd[k] * p_ir[k] * p_sr[k];
        set = 1'b0;
        if (!rst) begin
            m_mode[k]  = 0;
            m_t[k]     = 0;
            m_flush[k] = 0;
            m_uf[k]    = 1'b0;
            m_cur[k]   = '0;
            return;
        end
        case (m_mode[k])
            0: if (en) m_mode[k] = 1;
            1: begin
                if (!en) begin
                    m_mode[k] = 0;
                end else if (vld) begin
                    m_cur[k]  = dat;
                    m_t[k]    = 0;
                    m_mode[k] = 2;
                end
            end
            2: begin
                if (m_t[k] == per - 1) begin
                    m_t[k] = 0;
                    if (en) begin
                        if (vld) begin
                            m_cur[k] = dat;
                        end else begin
                            m_cur[k] = '0;
                            set      = 1'b1;
                        end
                    end else begin
                        m_cur[k]   = '0;
                        m_flush[k] = p_fs[k];
                        m_mode[k]  = 3;
                    end
                end else begin
                    m_t[k]++;
                end
            end
            default: begin
                if (m_t[k] == per - 1) begin
                    m_t[k] = 0;
                    if (m_flush[k] == 1) m_mode[k] = 0;
                    else                 m_flush[k]--;
                end else begin
                    m_t[k]++;
                end
            end
        endcase
        if (set)      m_uf[k] = 1'b1;
        else if (clr) m_uf[k] = 1'b0;
    endtask

    // One clock: drive on the falling edge, compare 1 ns later, advance the
    // model at the rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic vld, input logic clr);
        logic [17:0] dat;
        bit          hs;
        @(negedge clk);
        dat           = (src.size() > 0) ? src[0] : 18'($urandom);
        reset         = rst;
        enable        = en;
        sym_valid     = vld;
        sym_data      = dat;
        clr_underflow = clr;
        #1;
        hs = 1'b0;
        if (m_known) begin
            for (int k = 0; k < 2; k++) begin
                model_expect(k, en);
                observe(k);
                for (int j = 0; j < 8; j++) begin
                    checkOutput($sformatf("dut%0d.%s@%0d", k, names[j], cyc), obs_v[j], exp_v[j]);
                end
                if (k == 0) hs = exp_v[5][0] && vld;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k, rst, en, vld, clr, dat);
        if (!rst) m_known = 1'b1;
        if (hs && (src.size() > 0)) void'(src.pop_front());
        cyc++;
    endtask

    task automatic applySteps(input int n, input logic rst, input logic en, input logic vld, input logic clr);
        for (int i = 0; i < n; i++) applyStimulus(rst, en, vld, clr);
    endtask

    // Directed scenario sequence with randomised data and handshake gaps.
    initial begin
        reset         = 1'b0;
        enable        = 1'b0;
        sym_valid     = 1'b0;
        clr_underflow = 1'b0;
        sym_data      = '0;

        src.push_back(18'h00100);
        src.push_back(18'h00005);
        src.push_back(18'h3FFFD);
        src.push_back(18'h00007);

        // Held in reset with a live upstream and run request.
        applySteps(3, 1'b0, 1'b1, 1'b1, 1'b0);
        // Start-up and streaming of the directed symbols, then random data.
        applySteps(68, 1'b1, 1'b1, 1'b1, 1'b0);
        // One starved symbol slot, flag stays up, then a plain clear.
        applySteps(16, 1'b1, 1'b1, 1'b0, 1'b0);
        applySteps(16, 1'b1, 1'b1, 1'b1, 1'b0);
        applySteps(1,  1'b1, 1'b1, 1'b1, 1'b1);
        // Starved slot while clear is held: setting must win.
        applySteps(16, 1'b1, 1'b1, 1'b0, 1'b1);
        applySteps(8,  1'b1, 1'b1, 1'b1, 1'b0);
        // Random valid gaps and occasional clears.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 1'b1, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
        end
        // Enable drops across a symbol boundary, re-raised during flush.
        applySteps(20,  1'b1, 1'b0, 1'b1, 1'b0);
        applySteps(150, 1'b1, 1'b1, 1'b1, 1'b0);
        // Full flush down to idle.
        applySteps(150, 1'b1, 1'b0, 1'b1, 1'b0);
        // Priming with no data, then abandoned while data shows up.
        applySteps(3,  1'b1, 1'b1, 1'b0, 1'b0);
        applySteps(1,  1'b1, 1'b0, 1'b1, 1'b0);
        applySteps(40, 1'b1, 1'b1, 1'b1, 1'b0);
        // Reset in the middle of streaming, then restart.
        applySteps(1,  1'b0, 1'b1, 1'b1, 1'b0);
        applySteps(40, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
